// File: rtl/mu_rd_scheduler_pkg.sv
// Shared types and sizing constants for the motion-update read scheduler.
package mu_rd_scheduler_pkg;

    localparam int NUM_CELLS_PER_MU      = 4;
    localparam int PARTICLE_ID_WIDTH     = 9;
    localparam int NUM_PARTICLES_PER_RAM = 512;
    localparam int MU_SCHED_CREDITS      = 4;
    localparam int PART_CNT_WIDTH        = PARTICLE_ID_WIDTH + 1;
    localparam int CELL_COUNT_WIDTH      = $clog2(NUM_CELLS_PER_MU);

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_LOAD,
        MS_ISSUE,
        MS_DRAIN,
        MS_DONE
    } mu_sched_state_t;

endpackage

// File: rtl/mu_rd_scheduler_credit_counter.sv
// Saturating up/down credit counter that tracks reads in flight toward the MU input buffer.
module mu_credit_counter
    import mu_rd_scheduler_pkg::*;
#(
    parameter int CREDITS = MU_SCHED_CREDITS,
    parameter int CNT_W   = $clog2(CREDITS + 1)
)(
    input  logic clk,
    input  logic rst,
    input  logic i_dec,
    input  logic i_inc,
    output logic o_has_credit,
    output logic o_full
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] count_q;

    // Simultaneous take and give cancel out; both directions saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= FULL;
        end else begin
            case ({i_dec, i_inc})
                2'b10: if (count_q != '0) count_q <= count_q - CNT_W'(1);
                2'b01: if (count_q != FULL) count_q <= count_q + CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_has_credit = (count_q != '0);
    assign o_full       = (count_q == FULL);

    a_no_return_when_full: assert property (@(posedge clk) disable iff (rst)
        !(i_inc && !i_dec && o_full));

endmodule

// File: rtl/mu_rd_scheduler.sv
// Motion-update read scheduler: walks each cell's particles in order under credit throttling.
// Define MU_SCHED_STATS_EN to build the stall/read statistic counters (tied to 0 otherwise).
module mu_rd_scheduler
    import mu_rd_scheduler_pkg::*;
#(
    parameter int NUM_CELLS = NUM_CELLS_PER_MU,
    parameter int ADDR_W    = PARTICLE_ID_WIDTH,
    parameter int MAX_PARTS = NUM_PARTICLES_PER_RAM,
    parameter int CREDITS   = MU_SCHED_CREDITS,
    parameter int CELL_W    = $clog2(NUM_CELLS)
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_MU_start,
    input  logic [NUM_CELLS*(ADDR_W+1)-1:0] i_num_particles,
    input  logic                          i_credit_return,
    output logic [ADDR_W-1:0]             o_MU_rd_addr,
    output logic [NUM_CELLS-1:0]          o_MU_rd_en,
    output logic [CELL_W-1:0]             o_rd_cell,
    output logic                          o_MU_working,
    output logic                          o_MU_done,
    output logic [31:0]                   o_stall_cycles,
    output logic [31:0]                   o_total_reads
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PARTS);

    mu_sched_state_t   state, next_state;
    logic [CNT_W-1:0]  in_cnt   [NUM_CELLS];
    logic [CNT_W-1:0]  counts_q [NUM_CELLS];
    logic [CNT_W-1:0]  src_cnt  [NUM_CELLS];
    logic [CELL_W-1:0] cell_q, cur_cell, first_cell, next_cell;
    logic [ADDR_W-1:0] addr_q, cur_addr;
    logic              loading, any_nz, next_found, last_in_cell;
    logic              do_issue, issue_done;
    logic              has_credit, cred_full;

    mu_credit_counter #(.CREDITS(CREDITS)) u_credit (
        .clk          (clk),
        .rst          (rst),
        .i_dec        (do_issue),
        .i_inc        (i_credit_return),
        .o_has_credit (has_credit),
        .o_full       (cred_full)
    );

    always_comb begin
        for (int c = 0; c < NUM_CELLS; c++) begin
            in_cnt[c] = i_num_particles[c*CNT_W +: CNT_W];
            if (in_cnt[c] > MAX_CNT) in_cnt[c] = MAX_CNT;
        end
    end

    // During LOAD the first read is issued straight from the incoming counts, so the
    // pointer/lookup logic works from whichever count set is current.
    always_comb begin
        loading    = (state == MS_LOAD);
        any_nz     = 1'b0;
        first_cell = '0;
        next_found = 1'b0;
        next_cell  = '0;
        for (int c = NUM_CELLS - 1; c >= 0; c--) begin
            src_cnt[c] = loading ? in_cnt[c] : counts_q[c];
            if (src_cnt[c] != '0) begin
                any_nz     = 1'b1;
                first_cell = CELL_W'(c);
            end
        end
        cur_cell = loading ? first_cell : cell_q;
        cur_addr = loading ? '0 : addr_q;
        for (int c = NUM_CELLS - 1; c >= 0; c--) begin
            if (CELL_W'(c) > cur_cell && src_cnt[c] != '0) begin
                next_found = 1'b1;
                next_cell  = CELL_W'(c);
            end
        end
        last_in_cell = ({1'b0, cur_addr} == (src_cnt[cur_cell] - CNT_W'(1)));
        do_issue     = ((loading && any_nz) || state == MS_ISSUE) && has_credit;
        issue_done   = do_issue && last_in_cell && !next_found;

        next_state = state;
        case (state)
            MS_IDLE:  if (i_MU_start) next_state = MS_LOAD;
            MS_LOAD:  next_state = (!any_nz || issue_done) ? MS_DRAIN : MS_ISSUE;
            MS_ISSUE: if (issue_done) next_state = MS_DRAIN;
            MS_DRAIN: if (cred_full) next_state = MS_DONE;
            MS_DONE:  next_state = MS_IDLE;
            default:  next_state = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= MS_IDLE;
            counts_q     <= '{default: '0};
            cell_q       <= '0;
            addr_q       <= '0;
            o_MU_rd_en   <= '0;
            o_MU_rd_addr <= '0;
            o_rd_cell    <= '0;
            o_MU_working <= 1'b0;
            o_MU_done    <= 1'b0;
        end else begin
            state        <= next_state;
            o_MU_working <= (next_state != MS_IDLE);
            o_MU_done    <= (next_state == MS_DONE);
            o_MU_rd_en   <= '0;
            o_MU_rd_addr <= '0;
            o_rd_cell    <= '0;
            if (loading) begin
                counts_q <= in_cnt;
                cell_q   <= first_cell;
                addr_q   <= '0;
            end
            if (do_issue) begin
                o_MU_rd_en   <= NUM_CELLS'(1) << cur_cell;
                o_MU_rd_addr <= cur_addr;
                o_rd_cell    <= cur_cell;
                if (last_in_cell) begin
                    cell_q <= next_cell;
                    addr_q <= '0;
                end else begin
                    cell_q <= cur_cell;
                    addr_q <= cur_addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef MU_SCHED_STATS_EN
    logic [31:0] stall_q, reads_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            reads_q <= '0;
        end else begin
            if (state == MS_ISSUE && !has_credit && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (do_issue && reads_q != '1) reads_q <= reads_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_total_reads  = reads_q;
`else
    assign o_stall_cycles = '0;
    assign o_total_reads  = '0;
`endif

endmodule
